// File: rtl/mmio_input_controller_if.sv
// CPU load/store bus shared by the IO window: address, store data, strobes and the registered load return.
interface mmio_input_controller_if;
  logic [31:0] MemoryAdr;
  logic [31:0] MemoryData;
  logic        wen;
  logic        ren;
  logic [31:0] ReadData;
  logic        rvalid;

  modport master (output MemoryAdr, MemoryData, wen, ren, input ReadData, rvalid);
  modport slave  (input MemoryAdr, MemoryData, wen, ren, output ReadData, rvalid);
endinterface

// File: rtl/mmio_input_controller.sv
// Memory-mapped input peripheral: synchronized/debounced switches and buttons, W1C press events, masked irq.
// Loads return one cycle after ren as a single rvalid pulse; no backpressure, ReadData is only held that cycle.
module mmio_input_controller #(
  parameter int          NSW        = 10,
  parameter int          NBTN       = 4,
  parameter int          DEB_CYCLES = 50000,
  parameter logic [31:0] BASE_ADR   = 32'h8000_0100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mmio_input_controller_if.slave bus,
  input  logic [NSW-1:0]         sw_in,
  input  logic [NBTN-1:0]        btn_in,
  output logic                   irq
);
  localparam int NIN = NSW + NBTN;
  localparam int CW  = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_SW    = 2'd0,
    REG_BTN   = 2'd1,
    REG_EVENT = 2'd2,
    REG_MASK  = 2'd3
  } reg_sel_e;

  logic [NIN-1:0]         sync1_q, sync1_d;
  logic [NIN-1:0]         sync2_q, sync2_d;
  logic [NIN-1:0]         deb_q, deb_d;
  logic [NIN-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NBTN-1:0]        event_q, event_d;
  logic [NBTN-1:0]        mask_q, mask_d;
  logic                   irq_q, irq_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   hit;
  reg_sel_e               sel;
  logic [31:0]            reg_rd;
  logic [NBTN-1:0]        ev_clr;
  logic [NBTN-1:0]        btn_deb_q, btn_deb_d;
  logic                   unused_bits;

  assign unused_bits = ^{bus.MemoryAdr[1:0], bus.MemoryData};

  // Switches occupy the low bits of the shared sync/debounce vector, buttons the high bits.
  always_comb begin
    sync1_d = {btn_in, sw_in};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NIN; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign btn_deb_q = deb_q[NIN-1:NSW];
  assign btn_deb_d = deb_d[NIN-1:NSW];

  always_comb begin
    hit    = (bus.MemoryAdr[31:4] == BASE_ADR[31:4]);
    sel    = reg_sel_e'(bus.MemoryAdr[3:2]);
    reg_rd = '0;
    case (sel)
      REG_SW:    reg_rd = 32'(deb_q[NSW-1:0]);
      REG_BTN:   reg_rd = 32'(btn_deb_q);
      REG_EVENT: reg_rd = 32'(event_q);
      default:   reg_rd = 32'(mask_q);
    endcase

    ev_clr = (bus.wen && hit && sel == REG_EVENT) ? bus.MemoryData[NBTN-1:0] : '0;
    // A rising debounced edge in the same cycle as a W1C store keeps the bit set.
    event_d = (event_q & ~ev_clr) | (btn_deb_d & ~btn_deb_q);
    mask_d  = (bus.wen && hit && sel == REG_MASK) ? bus.MemoryData[NBTN-1:0] : mask_q;
    irq_d   = |(event_q & mask_q);

    // Read value is taken from pre-edge state, so same-cycle writes/events show on the next load.
    rvalid_d = bus.ren && hit;
    rdata_d  = rvalid_d ? reg_rd : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      event_q  <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      event_q  <= event_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.rvalid   = rvalid_q;
  assign bus.ReadData = rdata_q;
  assign irq          = irq_q;
endmodule

// File: doc/mmio_input_controller.md
Name: mmio_input_controller

Overview:
- Memory-mapped input peripheral: the CPU-load side of the IO window whose store side drives the 7-segment display.
- Synchronizes and debounces board switches and buttons.
- Latches button-press events.
- Returns register contents to the CPU on loads, plus an interrupt line.
- Sits beside the store-side memory controller on the same MemoryAdr/MemoryData/wen bus and adds a read path.

Parameters:
NSW, 10, number of slide switches (1..32)
NBTN, 4, number of push buttons (1..32)
DEB_CYCLES, 50000, consecutive stable cycles required before a debounced bit changes (>=1)
BASE_ADR, 32'h8000_0100, byte address of register 0; must be 16-byte aligned, bit 31 set

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
MemoryAdr  in  32  CPU byte address; bits [1:0] ignored
MemoryData  in  32  CPU store data, used for register writes
wen  in  1  store strobe
ren  in  1  load strobe
sw_in  in  NSW  raw asynchronous switch pins
btn_in  in  NBTN  raw asynchronous button pins, 1 = pressed
ReadData  out  32  load result
rvalid  out  1  one-cycle pulse: ReadData is valid
irq  out  1  level interrupt request

Behaviour:
- Reset (rst_n=0 at a posedge):
  - Clears all synchronizer flops, debounced state, debounce counters, EVENT, MASK, ReadData, rvalid, irq to 0.
  - Reset mid-debounce discards the count.
  - Reset the same cycle as ren: no rvalid next cycle.
- Synchronizer: 2 flops per input bit, no logic between stages.
- Debounce, independent per bit:
  - Counter width = clog2(DEB_CYCLES+1).
  - When the synchronized value equals the debounced value, the counter clears to 0.
  - Otherwise the counter increments. On the edge where the counter == DEB_CYCLES-1 and the mismatch persists, the debounced value takes the synchronized value and the counter clears.
  - A single-cycle glitch shorter than DEB_CYCLES never propagates.
  - Pin change before edge k -> debounced value changes at edge k+1+DEB_CYCLES.
- Register map (offset from BASE_ADR, word-aligned):
  - 0x0 SW: RO, {zeros, debounced switches}.
  - 0x4 BTN: RO, {zeros, debounced buttons}.
  - 0x8 EVENT: W1C.
    - Bit i sets on the cycle debounced btn[i] goes 0->1.
    - A store clears the bits where MemoryData is 1.
    - Set and clear of the same bit in the same cycle: set wins.
  - 0xC MASK: RW, NBTN bits; upper bits read 0, writes to them ignored.
  - Writes to SW/BTN are ignored.
- Decode: hit when MemoryAdr[31:4] == BASE_ADR[31:4]. Addresses outside the window produce no response and no side effect.
- Read timing, 1-cycle latency:
  - ren & hit at edge k -> rvalid=1 and ReadData=register value during cycle k+1 (registered).
  - rvalid falls after one cycle unless ren & hit again.
  - ReadData = 0 whenever rvalid = 0.
  - Back-to-back reads every cycle are supported.
- Read/write collisions:
  - ren and wen to the same register in the same cycle: the read returns the pre-write value.
  - An EVENT read in the same cycle an event sets returns the pre-set value; the new bit is visible on the next read.
- irq: registered, = |(EVENT & MASK). Updates one cycle after EVENT or MASK changes.
- No backpressure: the CPU must sample ReadData in the rvalid cycle.

Test Plan:
1. DEB_CYCLES=4, reset then release; drive sw_in=10'h2A5 at edge 10 -> debounced value changes at edge 15; ren to BASE+0 -> rvalid pulse, ReadData=32'h2A5; all outputs 0 while rst_n=0.
2. btn_in[2] glitch high for 3 cycles, DEB_CYCLES=4 -> BTN stays 0 and EVENT stays 0. Hold btn_in[2] high for 8 cycles -> BTN=4, EVENT=4.
3. MASK=4'h4 written, then btn[2] press -> irq=1 one cycle after the EVENT bit sets. Write 32'h4 to BASE+8 -> EVENT=0, irq=0 next cycle. Write 32'h1 instead -> EVENT stays 4.
4. W1C of bit 1 in the same cycle btn[1] rising event sets -> EVENT[1]=1 afterwards (set wins).
5. ren to BASE+0,4,8,C on four consecutive cycles -> four consecutive rvalid cycles with matching ReadData. ren to 0x8000_0064 -> rvalid stays 0, ReadData=0.
6. rst_n low for one edge mid-debounce (counter=2) plus pending EVENT -> all state 0. The held input then requires a full 2+DEB_CYCLES cycles to reappear.
